stc_acc_ctrl: RTL

Per-PE sequencer for the sparse tensor-core accumulator bank. Counts accepted multiplier beats per output tile and drives the accumulator's per-PE `acc_en` (psum load on the first beat of a tile). Gates the multiplier operand so the free-running accumulator holds between beats. Presents each finished tile through a valid/ready result handshake and back-pressures the PE until the result is drained. Sits between the PE multiplier pipelines, the psum fetch unit and the accumulator bank.

---
 rtl/stc_acc_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/stc_acc_ctrl.sv
// stc_acc_ctrl: per-PE beat/tile sequencer driving accumulator enables and result handshakes
module stc_acc_ctrl #(
  parameter int N_PE  = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cfg_k_beats,
  input  logic [CNT_W-1:0] i_cfg_n_tiles,
  output logic             o_busy,
  output logic             o_done,
  input  logic [N_PE-1:0]  i_mult_valid,
  output logic [N_PE-1:0]  o_mult_ready,
  output logic [N_PE-1:0]  o_mult_gate,
  output logic [N_PE-1:0]  o_acc_en,
  output logic [N_PE-1:0]  o_psum_req,
  output logic [N_PE-1:0]  o_res_valid,
  output logic [N_PE-1:0]  o_res_last,
  input  logic [N_PE-1:0]  i_res_ready
);
  typedef enum logic {G_IDLE, G_RUN} g_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ACC, P_HOLD, P_DONE} p_state_t;
  g_state_t         r_g, w_g_nxt;
  p_state_t         r_p [N_PE];
  p_state_t         w_p_nxt [N_PE];
  logic [CNT_W-1:0] r_beat [N_PE];
  logic [CNT_W-1:0] w_beat_nxt [N_PE];
  logic [CNT_W-1:0] r_tile [N_PE];
  logic [CNT_W-1:0] w_tile_nxt [N_PE];
  logic [CNT_W-1:0] r_k, r_n, w_k_nxt, w_n_nxt, w_k_m1, w_n_m1;
  logic [N_PE-1:0]  w_acc, w_hs, w_last_beat, w_pe_done;
  assign w_k_m1     = r_k - CNT_W'(1);
  assign w_n_m1     = r_n - CNT_W'(1);
  assign o_busy     = r_g == G_RUN;
  assign o_psum_req = o_acc_en;
  for (genvar g = 0; g < N_PE; g++) begin : g_pe
    assign w_acc[g]        = r_p[g] == P_ACC && i_mult_valid[g];
    assign w_last_beat[g]  = r_beat[g] == w_k_m1;
    assign w_pe_done[g]    = r_p[g] == P_DONE;
    assign o_mult_ready[g] = r_p[g] == P_ACC;
    assign o_mult_gate[g]  = w_acc[g];
    assign o_acc_en[g]     = w_acc[g] && r_beat[g] == '0;
    assign o_res_valid[g]  = r_p[g] == P_HOLD;
    assign o_res_last[g]   = o_res_valid[g] && r_tile[g] == w_n_m1;
    assign w_hs[g]         = o_res_valid[g] && i_res_ready[g];
  end
  always_comb begin
    w_g_nxt = r_g;
    w_k_nxt = r_k;
    w_n_nxt = r_n;
    o_done  = 1'b0;
    for (int i = 0; i < N_PE; i++) begin
      w_p_nxt[i]    = r_p[i];
      w_beat_nxt[i] = r_beat[i];
      w_tile_nxt[i] = r_tile[i];
      if (w_acc[i]) begin
        w_beat_nxt[i] = w_last_beat[i] ? '0 : r_beat[i] + CNT_W'(1);
        w_p_nxt[i]    = w_last_beat[i] ? P_HOLD : P_ACC;
      end
      if (w_hs[i]) begin
        w_p_nxt[i]    = o_res_last[i] ? P_DONE : P_ACC;
        w_tile_nxt[i] = o_res_last[i] ? r_tile[i] : r_tile[i] + CNT_W'(1);
      end
    end
    // an empty job (zero tiles) parks every PE in P_DONE so done fires on the next cycle
    if (r_g == G_IDLE && i_start) begin
      w_g_nxt = G_RUN;
      w_k_nxt = i_cfg_k_beats == '0 ? CNT_W'(1) : i_cfg_k_beats;
      w_n_nxt = i_cfg_n_tiles;
      for (int i = 0; i < N_PE; i++) begin
        w_p_nxt[i]    = i_cfg_n_tiles == '0 ? P_DONE : P_ACC;
        w_beat_nxt[i] = '0;
        w_tile_nxt[i] = '0;
      end
    end else if (r_g == G_RUN && &w_pe_done) begin
      o_done  = 1'b1;
      w_g_nxt = G_IDLE;
      for (int i = 0; i < N_PE; i++) w_p_nxt[i] = P_IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_g <= G_IDLE;
      r_k <= '0;
      r_n <= '0;
      for (int i = 0; i < N_PE; i++) begin
        r_p[i]    <= P_IDLE;
        r_beat[i] <= '0;
        r_tile[i] <= '0;
      end
    end else begin
      r_g <= w_g_nxt;
      r_k <= w_k_nxt;
      r_n <= w_n_nxt;
      for (int i = 0; i < N_PE; i++) begin
        r_p[i]    <= w_p_nxt[i];
        r_beat[i] <= w_beat_nxt[i];
        r_tile[i] <= w_tile_nxt[i];
      end
    end
  end
endmodule
